// File: rtl/regfile_sequencer.sv
// Command-driven initiator for the MIPS register_file: single writes,
// paired reads, bulk fill of r1..r31 and a full 32-register dump.
//
// Ports:
//   clock, reset            - clock, synchronous active-high reset
//   cmd_valid/cmd_ready     - host command handshake (accepted in IDLE)
//   cmd_op                  - 00 WRITE, 01 READ, 10 FILL, 11 DUMP
//   cmd_addr_a/cmd_addr_b   - write dest / read addresses
//   cmd_data                - WRITE and FILL value
//   rsp_valid/rsp_ready     - response handshake
//   rsp_addr, rsp_data_a/b  - RegA address and captured RD1/RD2
//   busy                    - high outside IDLE
//   RegA/RegB/RegC, dataIn, RegWrite, RD1/RD2 - register file side
module regfile_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [4:0]       cmd_addr_a,
  input  logic [4:0]       cmd_addr_b,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [4:0]       rsp_addr,
  output logic [WIDTH-1:0] rsp_data_a,
  output logic [WIDTH-1:0] rsp_data_b,
  output logic             busy,
  output logic [4:0]       RegA,
  output logic [4:0]       RegB,
  output logic [4:0]       RegC,
  output logic [WIDTH-1:0] dataIn,
  output logic             RegWrite,
  input  logic [WIDTH-1:0] RD1,
  input  logic [WIDTH-1:0] RD2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RESP,
    S_FILL,
    S_DUMP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [4:0]       r_addr_a;
  logic [4:0]       r_addr_b;
  logic [WIDTH-1:0] r_data;
  logic [4:0]       r_idx;
  logic             r_dumping;

  logic [4:0]       r_rega;
  logic [4:0]       r_regb;
  logic [4:0]       r_regc;
  logic [WIDTH-1:0] r_datain;

  logic [4:0]       r_rsp_addr;
  logic [WIDTH-1:0] r_rsp_a;
  logic [WIDTH-1:0] r_rsp_b;

  logic [4:0]       w_rega;
  logic [4:0]       w_regb;
  logic [4:0]       w_regc;
  logic [WIDTH-1:0] w_datain;
  logic             w_regwrite;
  logic             w_accept;
  logic             w_capture;
  logic             w_rsp_done;
  logic             w_cmd_ready;
  logic             w_busy;
  logic             w_rsp_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Register-file drive muxes default to the held values so the
  // address/data lines keep their last driven contents when idle.
  always_comb begin
    w_next      = r_state;
    w_cmd_ready = 1'b0;
    w_busy      = 1'b1;
    w_rsp_valid = 1'b0;
    w_rega      = r_rega;
    w_regb      = r_regb;
    w_regc      = r_regc;
    w_datain    = r_datain;
    w_regwrite  = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_rsp_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        w_busy      = 1'b0;
        if (cmd_valid) begin
          w_accept = 1'b1;
          unique case (cmd_op)
            2'b00: w_next = S_WRITE;
            2'b01: w_next = S_READ;
            2'b10: w_next = S_FILL;
            2'b11: w_next = S_DUMP;
          endcase
        end
      end
      S_WRITE: begin
        w_regc     = r_addr_a;
        w_datain   = r_data;
        w_regwrite = (r_addr_a != 5'd0);
        w_next     = S_IDLE;
      end
      S_READ: begin
        w_rega    = r_addr_a;
        w_regb    = r_addr_b;
        w_capture = 1'b1;
        w_next    = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_rsp_done = 1'b1;
          if (r_dumping && r_idx != 5'd30) begin
            w_next = S_DUMP;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      S_FILL: begin
        w_regc     = r_idx;
        w_datain   = r_data;
        w_regwrite = 1'b1;
        if (r_idx == 5'd31) begin
          w_next = S_IDLE;
        end
      end
      S_DUMP: begin
        w_rega    = r_idx;
        w_regb    = r_idx + 5'd1;
        w_capture = 1'b1;
        w_next    = S_RESP;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr_a   <= '0;
      r_addr_b   <= '0;
      r_data     <= '0;
      r_idx      <= '0;
      r_dumping  <= 1'b0;
      r_rega     <= '0;
      r_regb     <= '0;
      r_regc     <= '0;
      r_datain   <= '0;
      r_rsp_addr <= '0;
      r_rsp_a    <= '0;
      r_rsp_b    <= '0;
    end else begin
      r_rega   <= w_rega;
      r_regb   <= w_regb;
      r_regc   <= w_regc;
      r_datain <= w_datain;
      if (w_accept) begin
        r_addr_a  <= cmd_addr_a;
        r_addr_b  <= cmd_addr_b;
        r_data    <= cmd_data;
        r_dumping <= (cmd_op == 2'b11);
        r_idx     <= (cmd_op == 2'b10) ? 5'd1 : 5'd0;
      end
      if (r_state == S_FILL) begin
        r_idx <= r_idx + 5'd1;
      end
      if (w_capture) begin
        r_rsp_addr <= w_rega;
        r_rsp_a    <= RD1;
        r_rsp_b    <= RD2;
      end
      if (w_rsp_done && r_dumping) begin
        r_idx <= r_idx + 5'd2;
        if (r_idx == 5'd30) begin
          r_dumping <= 1'b0;
        end
      end
    end
  end

  assign cmd_ready  = w_cmd_ready;
  assign busy       = w_busy;
  assign rsp_valid  = w_rsp_valid;
  assign rsp_addr   = r_rsp_addr;
  assign rsp_data_a = r_rsp_a;
  assign rsp_data_b = r_rsp_b;
  assign RegA       = w_rega;
  assign RegB       = w_regb;
  assign RegC       = w_regc;
  assign dataIn     = w_datain;
  assign RegWrite   = w_regwrite;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural register
// file attached to its register-file port.
module tb_regfile_sequencer;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr_a;
  logic [4:0]  cmd_addr_b;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_addr;
  logic [31:0] rsp_data_a;
  logic [31:0] rsp_data_b;
  logic        busy;
  logic [4:0]  RegA;
  logic [4:0]  RegB;
  logic [4:0]  RegC;
  logic [31:0] dataIn;
  logic        RegWrite;
  logic [31:0] RD1;
  logic [31:0] RD2;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [32];
  logic [31:0] exp_rf [32];

  regfile_sequencer #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr_a (cmd_addr_a),
    .cmd_addr_b (cmd_addr_b),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_addr   (rsp_addr),
    .rsp_data_a (rsp_data_a),
    .rsp_data_b (rsp_data_b),
    .busy       (busy),
    .RegA       (RegA),
    .RegB       (RegB),
    .RegC       (RegC),
    .dataIn     (dataIn),
    .RegWrite   (RegWrite),
    .RD1        (RD1),
    .RD2        (RD2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (RegWrite && RegC != 5'd0) begin
      rf[RegC] <= dataIn;
    end
  end

  assign RD1 = (RegA == 5'd0) ? 32'd0 : rf[RegA];
  assign RD2 = (RegB == 5'd0) ? 32'd0 : rf[RegB];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 32; i++) exp_rf[i] = '0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [4:0] a,
                          input logic [4:0] b, input logic [31:0] d,
                          output int waited);
    logic acc;
    acc = 1'b0;
    waited = 0;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_addr_a = a;
    cmd_addr_b = b;
    cmd_data   = d;
    while (!acc && waited < 100) begin
      acc = cmd_ready;
      tick();
      waited++;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", {31'd0, acc}, 32'd1);
    if (op == 2'b00 && a != 5'd0) exp_rf[a] = d;
    if (op == 2'b10) begin
      for (int i = 1; i < 32; i++) exp_rf[i] = d;
    end
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    check("rsp_wait", {31'd0, rsp_valid}, 32'd1);
  endtask

  // mode 0: rsp_ready always high; mode 1: 1 cycle high, 2 low
  task automatic run_dump(input int mode, output int n, output int cyc);
    int w;
    int k;
    logic have_stall;
    logic [68:0] prev;
    n = 0;
    cyc = 0;
    k = 0;
    have_stall = 1'b0;
    prev = '0;
    send_cmd(2'b11, 5'd0, 5'd0, 32'd0, w);
    while ((busy || n == 0) && cyc < 200) begin
      rsp_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
      k++;
      if (rsp_valid) begin
        if (have_stall) begin
          check("rsp_stable", {31'd0, prev == {rsp_addr, rsp_data_a,
                rsp_data_b}}, 32'd1);
        end
        if (rsp_ready) begin
          check("dump_addr", {27'd0, rsp_addr}, 2 * n);
          check("dump_a", rsp_data_a, exp_rf[2 * n]);
          check("dump_b", rsp_data_b, exp_rf[2 * n + 1]);
          check("dump_cmd_rdy", {31'd0, cmd_ready}, 32'd0);
          n++;
        end
        have_stall = !rsp_ready;
        prev = {rsp_addr, rsp_data_a, rsp_data_b};
      end
      tick();
      cyc++;
    end
    rsp_ready = 1'b0;
    check("dump_cmd_rdy_end", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int w;
    int n;
    int cyc;
    int cnt;
    int g;
    logic regc_ok;

    reset      = 1'b1;
    cmd_valid  = 1'b1;
    cmd_op     = 2'b00;
    cmd_addr_a = 5'd3;
    cmd_addr_b = 5'd0;
    cmd_data   = 32'h1111_1111;
    rsp_ready  = 1'b0;
    clear_exp();

    tick();
    tick();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rega", {27'd0, RegA}, 32'd0);
    check("rst_regc", {27'd0, RegC}, 32'd0);
    check("rst_datain", dataIn, 32'd0);
    check("rst_rsp_a", rsp_data_a, 32'd0);
    check("rst_rsp_addr", {27'd0, rsp_addr}, 32'd0);
    cmd_valid = 1'b0;
    reset = 1'b0;
    tick();
    check("no_accept_in_rst", {31'd0, busy}, 32'd0);

    // single write then read
    send_cmd(2'b00, 5'd5, 5'd0, 32'hDEAD_BEEF, w);
    check("wr_regwrite", {31'd0, RegWrite}, 32'd1);
    check("wr_regc", {27'd0, RegC}, 32'd5);
    check("wr_datain", dataIn, 32'hDEAD_BEEF);
    check("wr_busy", {31'd0, busy}, 32'd1);
    tick();
    check("wr_done_rdy", {31'd0, cmd_ready}, 32'd1);
    check("wr_done_we", {31'd0, RegWrite}, 32'd0);

    send_cmd(2'b01, 5'd5, 5'd0, 32'd0, w);
    check("rd_n1_valid", {31'd0, rsp_valid}, 32'd0);
    check("rd_rega", {27'd0, RegA}, 32'd5);
    tick();
    check("rd_n2_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd_a", rsp_data_a, 32'hDEAD_BEEF);
    check("rd_b", rsp_data_b, 32'd0);
    check("rd_addr", {27'd0, rsp_addr}, 32'd5);
    tick();
    check("rd_hold_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd_hold_a", rsp_data_a, 32'hDEAD_BEEF);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rd_done_valid", {31'd0, rsp_valid}, 32'd0);

    // write to r0 is suppressed
    send_cmd(2'b00, 5'd0, 5'd0, 32'hFFFF_FFFF, w);
    check("wr0_regwrite", {31'd0, RegWrite}, 32'd0);
    tick();
    check("wr0_regwrite2", {31'd0, RegWrite}, 32'd0);
    send_cmd(2'b01, 5'd0, 5'd5, 32'd0, w);
    wait_rsp(cyc);
    check("rd0_a", rsp_data_a, 32'd0);
    check("rd0_b", rsp_data_b, 32'hDEAD_BEEF);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // read-after-write, back to back
    send_cmd(2'b00, 5'd7, 5'd0, 32'hA5A5_5A5A, w);
    send_cmd(2'b01, 5'd7, 5'd5, 32'd0, w);
    check("raw_wait", w, 32'd2);
    wait_rsp(cyc);
    check("raw_a", rsp_data_a, 32'hA5A5_5A5A);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // fill
    send_cmd(2'b10, 5'd0, 5'd0, 32'h1234_5678, w);
    cnt = 0;
    g = 0;
    regc_ok = 1'b1;
    while (busy && g < 40) begin
      if (RegWrite) begin
        if (RegC != 5'(cnt + 1) || dataIn != 32'h1234_5678) regc_ok = 1'b0;
        cnt++;
      end
      g++;
      tick();
    end
    check("fill_we_cycles", cnt, 32'd31);
    check("fill_busy_cycles", g, 32'd31);
    check("fill_regc_seq", {31'd0, regc_ok}, 32'd1);

    // dump, no back-pressure
    run_dump(0, n, cyc);
    check("dump_count", n, 32'd16);
    check("dump_cycles", cyc, 32'd32);

    // dump with back-pressure
    exp_rf[3] = 32'h0BAD_F00D;
    send_cmd(2'b00, 5'd3, 5'd0, 32'h0BAD_F00D, w);
    tick();
    run_dump(1, n, cyc);
    check("dump_bp_count", n, 32'd16);

    // READ held while a FILL runs
    send_cmd(2'b10, 5'd0, 5'd0, 32'hCAFE_F00D, w);
    send_cmd(2'b01, 5'd9, 5'd31, 32'd0, w);
    check("held_rd_wait", w, 32'd32);
    wait_rsp(cyc);
    check("held_rd_cyc", cyc, 32'd1);
    check("held_rd_a", rsp_data_a, 32'hCAFE_F00D);
    check("held_rd_b", rsp_data_b, 32'hCAFE_F00D);
    check("held_rd_addr", {27'd0, rsp_addr}, 32'd9);

    // reset drops a pending response
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_exp();
    check("rst_drop_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_drop_rdy", {31'd0, cmd_ready}, 32'd1);

    // reset in the middle of a fill
    send_cmd(2'b10, 5'd0, 5'd0, 32'h55AA_55AA, w);
    g = 0;
    while (!(RegWrite && RegC == 5'd10) && g < 40) begin
      tick();
      g++;
    end
    check("fill_reach_10", {27'd0, RegC}, 32'd10);
    reset = 1'b1;
    tick();
    check("abort_we", {31'd0, RegWrite}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rdy", {31'd0, cmd_ready}, 32'd1);
    reset = 1'b0;
    clear_exp();
    tick();
    run_dump(0, n, cyc);
    check("abort_dump_count", n, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
